letc_core_muldiv_sequencer: RTL and testbench
=============================================

Name: letc_core_muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit and its sequencing FSM.
- Sits beside the execute-stage ALU. While it is busy, execute holds e_ready low (e_ready = !busy, wired outside this block).
- Accepts one operation at a time through a valid/ready request and returns one result through a valid/ack response.
- Supports pipeline flush, so a squashed instruction aborts cleanly.

Parameters:
- FASTPATH_EN, default 1: when 1, divide-by-zero and signed overflow complete in 1 cycle; when 0, they run the full iteration and produce the same architectural result.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort any in-flight operation and drop any pending result
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted (high only in IDLE)
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (funct3 encoding)
- req_a  in  32  rs1 value
- req_b  in  32  rs2 value
- req_rd_idx  in  5  destination tag, returned with the result
- busy  out  1  state != IDLE
- result_valid  out  1  result available (high only in DONE)
- result_ack  in  1  consumer takes the result this cycle
- result  out  32  result word
- result_rd_idx  out  5  tag of the result

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE; busy = 0, req_ready = 1, result_valid = 0.
  - result = 0, result_rd_idx = 0, iteration counter = 0.
  - Reset mid-operation discards everything.
- States: IDLE, ITER, FIXUP, DONE.
- Accept: at an edge with req_valid && req_ready && !flush.
  - Latch op, tag and operand magnitudes.
  - Latch the result sign:
    - MUL*: XOR of the operand signs, per the signedness of each operand.
    - DIV: XOR of the operand signs.
    - REM: sign of the dividend.
  - Load the counter with 31 and go to ITER.
- ITER: one step per cycle; exit to FIXUP when counter == 0. There are exactly 32 ITER edges.
  - MUL: shift-add on 64-bit {hi, lo} using unsigned magnitudes.
  - DIV: restoring shift-subtract of 32 quotient bits, with a 33-bit partial remainder.
- FIXUP: one edge.
  - Conditionally negate the 64-bit product, the quotient or the remainder.
  - Select the result: lo for MUL; hi for MULH, MULHSU and MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Go to DONE.
- Latency: the acceptance edge is edge 0. result_valid first goes high after edge 33 and stays high until acked.
- DONE:
  - result and result_rd_idx are stable.
  - req_ready = 0, so a request cannot be accepted in the same cycle as an ack.
  - On result_ack go to IDLE at the next edge.
- Special cases. With FASTPATH_EN = 1 these are detected at acceptance and go straight to DONE (result_valid high after edge 0):
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = req_a.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Flush, at any edge:
  - The state goes to IDLE and result_valid is 0 the next cycle.
  - Flush takes priority over both request acceptance and result_ack.
  - Flush while in IDLE is a no-op.
- result_ack while not in DONE is ignored.
- Arithmetic rules:
  - Division truncates toward zero.
  - The remainder sign follows the dividend.
  - All negation is two's complement, and 0x80000000 magnitudes are handled as unsigned 32-bit.
- Simulation assertions:
  - result_valid implies state == DONE.
  - req_ready implies !busy.
  - result and result_rd_idx are stable while result_valid && !result_ack.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (−3):
   - result = 0xFFFFFFEB, valid first high after edge 33.
   - req_ready = 0 and busy = 1 throughout; result_rd_idx equals the request tag.
2. High-half multiplies:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
3. Signed and unsigned division:
   - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF.
   - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
4. Special cases:
   - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
   - Each completes 1 cycle after acceptance with FASTPATH_EN = 1, and 33 cycles after with FASTPATH_EN = 0, giving identical results.
5. Flush:
   - Flush at the 10th ITER edge → IDLE next cycle and result_valid never rises. A new MULHU 3 × 5 accepted the following cycle → 0.
   - Flush coincident with req_valid in IDLE → request not accepted.
   - Flush coincident with result_ack in DONE → IDLE.
6. Backpressure and reset:
   - result_ack held low for 5 cycles in DONE → result, result_rd_idx and result_valid held and req_ready = 0. Ack → IDLE next cycle.
   - rst_n low mid-ITER → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/letc_core_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// One operation at a time: valid/ready request in, valid/ack result out.
// 32 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) steps on
// unsigned magnitudes, followed by a single sign fix-up cycle.
module letc_core_muldiv_sequencer #(
  parameter bit FASTPATH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd_idx,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [31:0] result,
  output logic [4:0]  result_rd_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;     // product high word / partial remainder
  logic [31:0] lo_q;     // product low word / dividend shifting into quotient
  logic [31:0] bmag_q;   // multiplicand / divisor magnitude

  // Request decode
  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, fast, sign_nxt;
  logic [31:0] fast_result;

  // Iteration step and fix-up datapath
  logic [32:0] mul_sum, mul_add;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] div_rem_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  // Decode operand signedness, magnitudes, result sign and special cases
  always_comb begin
    accept   = (state == IDLE) && req_valid && !flush;
    a_signed = req_op[2] ? !req_op[0] : (req_op != 3'd3);
    b_signed = req_op[2] ? !req_op[0] : (req_op[1] == 1'b0);
    a_neg    = a_signed && req_a[31];
    b_neg    = b_signed && req_b[31];
    mag_a    = a_neg ? (32'd0 - req_a) : req_a;
    mag_b    = b_neg ? (32'd0 - req_b) : req_b;
    div_zero = req_op[2] && (req_b == '0);
    div_ovf  = req_op[2] && !req_op[0] && (req_a == 32'h8000_0000) && (req_b == '1);
    fast     = FASTPATH_EN && (div_zero || div_ovf);
    // Restoring division by zero yields an all-ones quotient magnitude,
    // so the quotient sign is suppressed to keep 0xFFFFFFFF un-negated.
    if (!req_op[2])     sign_nxt = a_neg ^ b_neg;
    else if (req_op[1]) sign_nxt = a_neg;
    else                sign_nxt = (a_neg ^ b_neg) && !div_zero;
    if (div_zero) fast_result = req_op[1] ? req_a : '1;
    else          fast_result = req_op[1] ? '0 : 32'h8000_0000;
  end

  // One multiply or divide step, plus sign fix-up and result select
  always_comb begin
    mul_sum     = {1'b0, hi_q} + {1'b0, bmag_q};
    mul_add     = lo_q[0] ? mul_sum : {1'b0, hi_q};
    div_trial   = {hi_q, lo_q[31]};
    div_ge      = (div_trial >= {1'b0, bmag_q});
    div_rem_nxt = div_ge ? (div_trial[31:0] - bmag_q) : div_trial[31:0];
    prod_fix    = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    quo_fix     = neg_q ? (32'd0 - lo_q) : lo_q;
    rem_fix     = neg_q ? (32'd0 - hi_q) : hi_q;
    case (op_q)
      3'd0:             fix_result = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: fix_result = prod_fix[63:32];
      3'd4, 3'd5:       fix_result = quo_fix;
      default:          fix_result = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides acceptance and acknowledgement
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state_nxt = fast ? DONE : ITER;
        ITER:    if (cnt_q == '0) state_nxt = FIXUP;
        FIXUP:   state_nxt = DONE;
        DONE:    if (result_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand latching, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q          <= '0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      bmag_q        <= '0;
      result        <= '0;
      result_rd_idx <= '0;
    end else if (accept) begin
      op_q          <= req_op;
      neg_q         <= sign_nxt;
      cnt_q         <= 5'd31;
      hi_q          <= '0;
      lo_q          <= mag_a;
      bmag_q        <= mag_b;
      result_rd_idx <= req_rd_idx;
      if (fast) result <= fast_result;
    end else if (!flush && state == ITER) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
      if (!op_q[2]) begin
        hi_q <= mul_add[32:1];
        lo_q <= {mul_add[0], lo_q[31:1]};
      end else begin
        hi_q <= div_rem_nxt;
        lo_q <= {lo_q[30:0], div_ge};
      end
    end else if (!flush && state == FIXUP) begin
      result <= fix_result;
    end
  end

  a_valid_in_done: assert property (@(posedge clk) disable iff (!rst_n)
    result_valid |-> state == DONE);
  a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    req_ready |-> !busy);
  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (result_valid && !result_ack) |=> ($stable(result) && $stable(result_rd_idx)));

endmodule

// File: tb/tb_letc_core_muldiv_sequencer.sv
// Randomized and directed checks of the RV32M muldiv sequencer against an
// arithmetic reference model. Instance 0 has the fast path enabled,
// instance 1 runs every operation through the full iteration.
module tb_letc_core_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [2:0]  req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [4:0]  req_rd_idx [2];
  logic        busy [2];
  logic        result_valid [2];
  logic        result_ack [2];
  logic [31:0] result [2];
  logic [4:0]  result_rd_idx [2];

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  letc_core_muldiv_sequencer #(.FASTPATH_EN(1'b1)) u_fast (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_rd_idx(req_rd_idx[0]),
    .busy(busy[0]), .result_valid(result_valid[0]), .result_ack(result_ack[0]),
    .result(result[0]), .result_rd_idx(result_rd_idx[0])
  );

  letc_core_muldiv_sequencer #(.FASTPATH_EN(1'b0)) u_slow (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_rd_idx(req_rd_idx[1]),
    .busy(busy[1]), .result_valid(result_valid[1]), .result_ack(result_ack[1]),
    .result(result[1]), .result_rd_idx(result_rd_idx[1])
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Architectural RV32M result computed with plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa, sb, q;
    longint      p;
    logic [63:0] u;
    logic [63:0] ub;
    logic        ovf;
    sa  = a;
    sb  = b;
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_result = '0;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); ref_result = p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); ref_result = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(ub); ref_result = p[63:32]; end
      3'd3: begin u = {32'h0, a} * ub; ref_result = u[63:32]; end
      3'd4: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (ovf) ref_result = 32'h8000_0000;
        else begin q = sa / sb; ref_result = q; end
      end
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_result = a;
        else if (ovf) ref_result = 0;
        else begin q = sa % sb; ref_result = q; end
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges between acceptance and result_valid for a given instance
  function automatic int exp_latency(input int i, input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit special;
    special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (i == 0 && special) ? 0 : 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      4: return 32'd0 - $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, wait for its result, hold ack low for 'hold'
  // cycles, then ack (optionally together with flush)
  task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input int hold,
                        input bit flush_ack);
    logic [31:0] exp;
    int lat;
    int bad;
    exp = ref_result(op, a, b);
    @(negedge clk);
    check("ready_idle", {31'b0, req_ready[i]}, 32'd1);
    req_valid[i] = 1'b1; req_op[i] = op; req_a[i] = a; req_b[i] = b; req_rd_idx[i] = tag;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    bad = 0;
    while (!result_valid[i] && lat < 40) begin
      if (req_ready[i] || !busy[i]) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency i%0d op%0d", i, op), lat, exp_latency(i, op, a, b));
    check("busy_while_running", bad, 0);
    check($sformatf("result i%0d op%0d a=%h b=%h", i, op, a, b), result[i], exp);
    check("rd_idx", {27'b0, result_rd_idx[i]}, {27'b0, tag});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, result_valid[i]}, 32'd1);
      check("bp_ready", {31'b0, req_ready[i]}, 32'd0);
      check("bp_result", result[i], exp);
      check("bp_rd_idx", {27'b0, result_rd_idx[i]}, {27'b0, tag});
    end
    @(negedge clk);
    result_ack[i] = 1'b1;
    flush[i] = flush_ack;
    @(posedge clk); #1;
    result_ack[i] = 1'b0;
    flush[i] = 1'b0;
    check("ack_busy", {31'b0, busy[i]}, 32'd0);
    check("ack_valid", {31'b0, result_valid[i]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0; req_valid[i] = 1'b0; req_op[i] = '0; req_a[i] = '0;
      req_b[i] = '0; req_rd_idx[i] = '0; result_ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy[0]}, 32'd0);
    check("rst_ready", {31'b0, req_ready[0]}, 32'd1);
    check("rst_valid", {31'b0, result_valid[0]}, 32'd0);
    check("rst_result", result[0], 32'd0);
    check("rst_rd_idx", {27'b0, result_rd_idx[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiplies and divides
    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 1'b0);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, 1'b0);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 1'b0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1'b0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b0);
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd7, 0, 1'b0);
    run_op(0, 3'd7, 32'd100, 32'd7, 5'd8, 0, 1'b0);

    // Divide by zero and signed overflow on both instances
    for (int i = 0; i < 2; i++) begin
      run_op(i, 3'd4, 32'd5, 32'd0, 5'd10, 0, 1'b0);
      run_op(i, 3'd6, 32'd5, 32'd0, 5'd11, 0, 1'b0);
      run_op(i, 3'd5, 32'd5, 32'd0, 5'd12, 0, 1'b0);
      run_op(i, 3'd7, 32'd5, 32'd0, 5'd13, 0, 1'b0);
      run_op(i, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 1'b0);
      run_op(i, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0, 1'b0);
    end

    // Backpressure: ack withheld for 5 cycles
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd21, 5, 1'b0);

    // Flush at the 10th ITER edge, then a fresh MULHU the next cycle
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 3'd0; req_a[0] = 32'd123; req_b[0] = 32'd456;
    req_rd_idx[0] = 5'd9;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("flush_iter_busy", {31'b0, busy[0]}, 32'd0);
    check("flush_iter_valid", {31'b0, result_valid[0]}, 32'd0);
    run_op(0, 3'd3, 32'd3, 32'd5, 5'd22, 0, 1'b0);

    // Flush coincident with a request in IDLE
    @(negedge clk);
    req_valid[0] = 1'b1; flush[0] = 1'b1; req_op[0] = 3'd0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; flush[0] = 1'b0;
    check("flush_req_busy", {31'b0, busy[0]}, 32'd0);
    check("flush_req_ready", {31'b0, req_ready[0]}, 32'd1);

    // Flush coincident with ack in DONE
    run_op(0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd23, 1, 1'b1);

    // Reset in the middle of an iteration
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 3'd4; req_a[0] = 32'd1000; req_b[0] = 32'd3;
    req_rd_idx[0] = 5'd17;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready[0]}, 32'd1);
    check("mid_rst_valid", {31'b0, result_valid[0]}, 32'd0);
    check("mid_rst_result", result[0], 32'd0);
    check("mid_rst_rd_idx", {27'b0, result_rd_idx[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized operations on both instances
    for (int n = 0; n < 60; n++) begin
      run_op(0, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'b0);
    end
    for (int n = 0; n < 20; n++) begin
      run_op(1, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)), $urandom_range(0, 1), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
